// File: rtl/sort_pkg.sv
// -----------------------------------------------------------------------------
// sort_pkg
// Shared definitions for the sorted-stream result checker:
//   - default data width and required packet length
//   - checker FSM state encoding
//   - bit positions inside the chk_err flag vector
// -----------------------------------------------------------------------------
package sort_pkg;

    localparam int SORT_DATA_WIDTH = 32;
    localparam int SORT_MAX_LENGTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECV   = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

    // chk_err bit positions
    localparam int ERR_ORPHAN  = 0;  // beat outside a packet
    localparam int ERR_DUP_SOP = 1;  // sop seen while a packet was open
    localparam int ERR_ORDER   = 2;  // word smaller than its predecessor
    localparam int ERR_LENGTH  = 3;  // beat count differs from MAX_LENGTH

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Unsigned counter that adds a small amount when enabled and sticks at its
// all-ones value instead of wrapping.
// Ports:
//   clk_i     clock (rising edge)
//   rst_ni    asynchronous active-low reset, clears the count
//   inc       add 'amount' this cycle
//   amount    increment value
//   count_o   registered count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc,
    input  logic [AMT_W-1:0] amount,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH:0]   sum_ext;

    always_comb begin
        sum_ext = {1'b0, count_q} + (WIDTH + 1)'(amount);
        count_d = count_q;
        if (inc) begin
            // carry out of the top bit means the true value passed all-ones
            count_d = sum_ext[WIDTH] ? {WIDTH{1'b1}} : sum_ext[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/sort_result_checker.sv
// -----------------------------------------------------------------------------
// sort_result_checker
// Watches the output stream of a sorter and, for every packet, reports whether
// it was well framed, non-decreasing and exactly MAX_LENGTH beats long, along
// with the packet checksum.
// Ports:
//   snk_clock    clock, all logic on its rising edge
//   snk_reset_n  asynchronous active-low reset
//   snk_data     data word of the current beat
//   snk_valid    beat qualifier (sop/eop ignored when low)
//   snk_sop      first beat of a packet
//   snk_eop      last beat of a packet
//   snk_ready    low in reset, high otherwise
//   chk_done     one-cycle pulse per reported packet
//   chk_pass     result of the last report
//   chk_err      {length, order, dup sop, orphan} flags
//   chk_sum      checksum of the last report
//   pkt_cnt      saturating count of reports
//   err_cnt      saturating count of error events
//   dbg_state    current FSM state
//
// Handshake: a beat transfers on every rising edge where snk_valid is high.
// The checker never back-pressures, so snk_ready is purely informational; a
// beat presented in the first cycle after reset release is accepted even
// though the registered snk_ready only rises on that same edge.
// -----------------------------------------------------------------------------
module sort_result_checker
    import sort_pkg::*;
#(
    parameter int DATA_WIDTH = SORT_DATA_WIDTH,
    parameter int MAX_LENGTH = SORT_MAX_LENGTH,
    localparam int SUMW      = DATA_WIDTH + $clog2(MAX_LENGTH + 1)
) (
    input  logic                  snk_clock,
    input  logic                  snk_reset_n,
    input  logic [DATA_WIDTH-1:0] snk_data,
    input  logic                  snk_valid,
    input  logic                  snk_sop,
    input  logic                  snk_eop,
    output logic                  snk_ready,
    output logic                  chk_done,
    output logic                  chk_pass,
    output logic [3:0]            chk_err,
    output logic [SUMW-1:0]       chk_sum,
    output logic [15:0]           pkt_cnt,
    output logic [15:0]           err_cnt,
    output logic [1:0]            dbg_state
);

    // Beat counter must hold MAX_LENGTH+1 (the "too long" marker).
    localparam int CNTW = $clog2(MAX_LENGTH + 2);
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(MAX_LENGTH);
    localparam logic [CNTW-1:0] CNT_OVF = CNTW'(MAX_LENGTH + 1);

    state_e                state_q, state_d;
    logic [CNTW-1:0]       count_q, count_d;
    logic [SUMW-1:0]       sum_q, sum_d;
    logic [DATA_WIDTH-1:0] prev_q, prev_d;
    logic [3:0]            flags_q, flags_d;   // live flags of the open packet
    logic                  ready_q;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic [SUMW-1:0]       rsum_q, rsum_d;
    logic [3:1]            rerr_q, rerr_d;     // packet flags frozen at report

    logic                  ev_orphan;
    logic                  ev_dup;
    logic                  report;
    logic [1:0]            err_amt;

    always_comb begin
        state_d   = (state_q == ST_REPORT) ? ST_IDLE : state_q;
        count_d   = count_q;
        sum_d     = sum_q;
        prev_d    = prev_q;
        flags_d   = flags_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        rsum_d    = rsum_q;
        rerr_d    = rerr_q;
        ev_orphan = 1'b0;
        ev_dup    = 1'b0;
        report    = 1'b0;

        if (snk_valid) begin
            if (snk_sop) begin
                // A sop always (re)starts a packet; inside RECV it also
                // abandons the open one and is flagged as a duplicate.
                ev_dup                = (state_q == ST_RECV);
                count_d               = CNT_ONE;
                sum_d                 = SUMW'(snk_data);
                prev_d                = snk_data;
                flags_d               = '0;
                flags_d[ERR_DUP_SOP]  = ev_dup;
                if (snk_eop) begin
                    report              = 1'b1;
                    flags_d[ERR_LENGTH] = (MAX_LENGTH != 1);
                    state_d             = ST_REPORT;
                end else begin
                    state_d = ST_RECV;
                end
            end else if (state_q == ST_RECV) begin
                if (snk_data < prev_q) begin
                    flags_d[ERR_ORDER] = 1'b1;
                end
                prev_d = snk_data;
                sum_d  = sum_q + SUMW'(snk_data);
                // Overlength is flagged on the offending beat, not at eop.
                if (count_q >= CNT_MAX) begin
                    count_d             = CNT_OVF;
                    flags_d[ERR_LENGTH] = 1'b1;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
                if (snk_eop) begin
                    if (count_d != CNT_MAX) begin
                        flags_d[ERR_LENGTH] = 1'b1;
                    end
                    report  = 1'b1;
                    state_d = ST_REPORT;
                end
            end else begin
                // Beat outside any packet: dropped, sticky until next sop.
                ev_orphan           = 1'b1;
                flags_d[ERR_ORPHAN] = 1'b1;
            end
        end

        // Results are registered on the eop edge so they are visible during
        // the REPORT cycle, together with the done pulse.
        if (report) begin
            done_d = 1'b1;
            pass_d = ~|flags_d[3:1];
            rsum_d = sum_d;
            rerr_d = flags_d[3:1];
        end

        err_amt = {1'b0, ev_orphan} + {1'b0, ev_dup}
                + {1'b0, report & (flags_d[ERR_ORDER] | flags_d[ERR_LENGTH])};
    end

    always_ff @(posedge snk_clock or negedge snk_reset_n) begin
        if (!snk_reset_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            sum_q   <= '0;
            prev_q  <= '0;
            flags_q <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            rsum_q  <= '0;
            rerr_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            prev_q  <= prev_d;
            flags_q <= flags_d;
            ready_q <= 1'b1;
            done_q  <= done_d;
            pass_q  <= pass_d;
            rsum_q  <= rsum_d;
            rerr_q  <= rerr_d;
        end
    end

    sat_counter #(
        .WIDTH (16),
        .AMT_W (2)
    ) u_pkt_cnt (
        .clk_i   (snk_clock),
        .rst_ni  (snk_reset_n),
        .inc     (report),
        .amount  (2'd1),
        .count_o (pkt_cnt)
    );

    sat_counter #(
        .WIDTH (16),
        .AMT_W (2)
    ) u_err_cnt (
        .clk_i   (snk_clock),
        .rst_ni  (snk_reset_n),
        .inc     (|err_amt),
        .amount  (err_amt),
        .count_o (err_cnt)
    );

    assign snk_ready = ready_q;
    assign chk_done  = done_q;
    assign chk_pass  = pass_q;
    assign chk_err   = {rerr_q, flags_q[ERR_ORPHAN]};
    assign chk_sum   = rsum_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sort_result_checker.sv
// -----------------------------------------------------------------------------
// tb_sort_result_checker
// Bench for sort_result_checker with DATA_WIDTH=8, MAX_LENGTH=4.
// -----------------------------------------------------------------------------
module tb_sort_result_checker;

  localparam int DW   = 8;
  localparam int ML   = 4;
  localparam int SUMW = DW + $clog2(ML + 1);
  // exp_q entry: {cycle[79:48], pass[47], err[46:43], sum[42:32], pkt[31:16], errc[15:0]}
  localparam int EW   = 80;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] data = '0;
  logic          valid = 1'b0;
  logic          sop = 1'b0;
  logic          eop = 1'b0;

  logic            snk_ready;
  logic            chk_done;
  logic            chk_pass;
  logic [3:0]      chk_err;
  logic [SUMW-1:0] chk_sum;
  logic [15:0]     pkt_cnt;
  logic [15:0]     err_cnt;
  logic [1:0]      dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sort_result_checker #(
    .DATA_WIDTH (DW),
    .MAX_LENGTH (ML)
  ) dut (
    .snk_clock   (clk),
    .snk_reset_n (rst_n),
    .snk_data    (data),
    .snk_valid   (valid),
    .snk_sop     (sop),
    .snk_eop     (eop),
    .snk_ready   (snk_ready),
    .chk_done    (chk_done),
    .chk_pass    (chk_pass),
    .chk_err     (chk_err),
    .chk_sum     (chk_sum),
    .pkt_cnt     (pkt_cnt),
    .err_cnt     (err_cnt),
    .dbg_state   (dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ready"}, 64'(snk_ready), 64'd0);
    check_eq({tag, "_done"},  64'(chk_done),  64'd0);
    check_eq({tag, "_pass"},  64'(chk_pass),  64'd0);
    check_eq({tag, "_err"},   64'(chk_err),   64'd0);
    check_eq({tag, "_sum"},   64'(chk_sum),   64'd0);
    check_eq({tag, "_pkt"},   64'(pkt_cnt),   64'd0);
    check_eq({tag, "_errc"},  64'(err_cnt),   64'd0);
    check_eq({tag, "_state"}, 64'(dbg_state), 64'd0);
  endtask

  // ---------------- scoreboard ----------------
  logic [EW-1:0]   exp_q[$];
  int              exp_pkt  = 0;
  int              exp_errc = 0;
  logic            last_pass = 1'b0;
  logic [SUMW-1:0] last_sum  = '0;

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  // Called right after the eop beat is driven: done is due on the next cycle.
  task automatic push_exp(input logic p, input logic [3:0] e, input logic [SUMW-1:0] s);
    exp_pkt = sat16(exp_pkt + 1);
    if (e[2] || e[3]) exp_errc = sat16(exp_errc + 1);
    exp_q.push_back({32'(cyc + 1), p, e, s, 16'(exp_pkt), 16'(exp_errc)});
  endtask

  task automatic mon_loop();
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (chk_done) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_done", 64'(chk_done), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("done_cycle", 64'(cyc),     64'(e[79:48]));
          check_eq("pass",       64'(chk_pass), 64'(e[47]));
          check_eq("err",        64'(chk_err),  64'(e[46:43]));
          check_eq("sum",        64'(chk_sum),  64'(e[42:32]));
          check_eq("pkt_cnt",    64'(pkt_cnt),  64'(e[31:16]));
          check_eq("err_cnt",    64'(err_cnt),  64'(e[15:0]));
          last_pass = e[47];
          last_sum  = e[42:32];
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  logic [DW-1:0] pkt_d[16];

  task automatic drive_beat(input logic [DW-1:0] d, input logic s, input logic e);
    @(negedge clk);
    valid = 1'b1;
    data  = d;
    sop   = s;
    eop   = e;
  endtask

  task automatic drive_idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid = 1'b0;
      sop   = 1'b0;
      eop   = 1'b0;
    end
  endtask

  // Well-framed packet from pkt_d[0:n-1]; expectation from a packet-level model.
  task automatic send_clean(input int n);
    logic [SUMW-1:0] s;
    logic            ord;
    logic            len_bad;
    s   = '0;
    ord = 1'b0;
    for (int i = 0; i < n; i++) begin
      s = s + SUMW'(pkt_d[i]);
      if (i > 0 && pkt_d[i] < pkt_d[i-1]) ord = 1'b1;
    end
    len_bad = (n != ML);
    for (int i = 0; i < n; i++) drive_beat(pkt_d[i], i == 0, i == n - 1);
    push_exp(!(ord || len_bad), {len_bad, ord, 2'b00}, s);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check_eq(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    fork
      mon_loop();
    join_none

    repeat (3) @(negedge clk);
    check_all_zero("reset");

    // Release and present a sop in the very first active cycle: 1,2,2,7.
    @(negedge clk);
    rst_n = 1'b1;
    valid = 1'b1; data = 8'd1; sop = 1'b1; eop = 1'b0;
    drive_beat(8'd2, 1'b0, 1'b0);
    drive_beat(8'd2, 1'b0, 1'b0);
    drive_beat(8'd7, 1'b0, 1'b1);
    push_exp(1'b1, 4'b0000, 11'd12);
    drive_idle(1);
    check_eq("ready_after_release", 64'(snk_ready), 64'd1);

    // Order violation: 3,1,4,5.
    drive_beat(8'd3, 1'b1, 1'b0);
    drive_beat(8'd1, 1'b0, 1'b0);
    drive_beat(8'd4, 1'b0, 1'b0);
    drive_beat(8'd5, 1'b0, 1'b1);
    push_exp(1'b0, 4'b0100, 11'd13);
    drive_idle(2);

    // Short packet 2,3,9 then long packet 1..5.
    drive_beat(8'd2, 1'b1, 1'b0);
    drive_beat(8'd3, 1'b0, 1'b0);
    drive_beat(8'd9, 1'b0, 1'b1);
    push_exp(1'b0, 4'b1000, 11'd14);
    drive_idle(1);
    for (int i = 1; i <= 5; i++) drive_beat(8'(i), i == 1, i == 5);
    push_exp(1'b0, 4'b1000, 11'd15);
    drive_idle(2);

    // Duplicate sop: 1,2 then restart at 5,6,7,8.
    drive_beat(8'd1, 1'b1, 1'b0);
    drive_beat(8'd2, 1'b0, 1'b0);
    drive_beat(8'd5, 1'b1, 1'b0);
    exp_errc = sat16(exp_errc + 1);
    drive_beat(8'd6, 1'b0, 1'b0);
    drive_beat(8'd7, 1'b0, 1'b0);
    drive_beat(8'd8, 1'b0, 1'b1);
    push_exp(1'b0, 4'b0010, 11'd26);
    drive_idle(1);

    // Random packets: mostly sorted, some disorder, lengths around ML,
    // including single-beat and back-to-back (sop in REPORT cycle).
    for (int p = 0; p < 12; p++) begin
      int n;
      int sorted;
      n      = $urandom_range(1, 6);
      sorted = $urandom_range(0, 2);
      pkt_d[0] = 8'($urandom_range(0, 100));
      for (int i = 1; i < n; i++) begin
        if (sorted != 0) pkt_d[i] = pkt_d[i-1] + 8'($urandom_range(0, 30));
        else             pkt_d[i] = 8'($urandom_range(0, 255));
      end
      if (p == 0) n = ML;  // guarantee at least one random exact-length packet
      send_clean(n);
      drive_idle($urandom_range(0, 2));
    end
    drive_idle(1);
    drain("drain_main");

    // Results hold after the report.
    drive_idle(3);
    check_eq("hold_pass", 64'(chk_pass), 64'(last_pass));
    check_eq("hold_sum",  64'(chk_sum),  64'(last_sum));

    // Orphan beat while idle.
    drive_beat(8'd9, 1'b0, 1'b0);
    exp_errc = sat16(exp_errc + 1);
    drive_idle(1);
    check_eq("orphan_flag",   64'(chk_err[0]), 64'd1);
    check_eq("orphan_errcnt", 64'(err_cnt),    64'(exp_errc));
    drive_idle(2);
    check_eq("orphan_held",   64'(chk_err[0]), 64'd1);

    // Next sop clears the orphan flag; then reset mid-packet.
    drive_beat(8'd1, 1'b1, 1'b0);
    drive_beat(8'd2, 1'b0, 1'b0);
    drive_idle(1);
    check_eq("orphan_cleared", 64'(chk_err[0]), 64'd0);
    check_eq("mid_pkt_state",  64'(dbg_state),  64'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    exp_pkt  = 0;
    exp_errc = 0;
    drive_beat(8'd3, 1'b0, 1'b1);   // eop while in reset must not report
    drive_idle(2);
    check_all_zero("held_reset");
    rst_n = 1'b1;

    // First packet after reset starts counters from zero.
    for (int i = 0; i < ML; i++) pkt_d[i] = 8'(10 + i);
    send_clean(ML);
    drive_idle(1);
    drain("drain_final");
    check_eq("final_pkt_cnt", 64'(pkt_cnt), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (checks=%0d)", n_checks);
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "timeout");
  end

endmodule
